// File: rtl/read_burst_capture_pkg.sv
// Shared read-path definitions: FSM states, burst lengths and deserialiser geometry
// used by the read burst capture stage.
package read_burst_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam int BL16_BEATS = 16;
    localparam int BC8_BEATS  = 8;

    localparam logic BL_SEL_BL16 = 1'b0;
    localparam logic BL_SEL_BC8  = 1'b1;

    localparam int BEAT_CNT_W   = 5;
    localparam int OFFSET_CNT_W = 3;

    localparam int SLOTS_PER_WORD = 4;
    localparam int SLOT_W         = 2;

    // Index of the final beat of a burst, compared against the running beat counter.
    function automatic logic [BEAT_CNT_W-1:0] last_beat_index(input logic bl_sel);
        if (bl_sel == BL_SEL_BC8) begin
            return BEAT_CNT_W'(BC8_BEATS - 1);
        end
        return BEAT_CNT_W'(BL16_BEATS - 1);
    endfunction

endpackage

// File: rtl/read_burst_capture_rd_deserializer.sv
// Four-slot beat collector: stores beats 0..2, and on slot 3 emits the packed word
// with a one-cycle valid strobe. The output word holds until the next one.
module rd_deserializer
    import read_burst_capture_pkg::*;
#(
    parameter int DQ_WIDTH = 8
)
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               capture_en,
    input  logic [SLOT_W-1:0]                  slot,
    input  logic [DQ_WIDTH-1:0]                dq,
    output logic [SLOTS_PER_WORD*DQ_WIDTH-1:0] word,
    output logic                               word_valid
);

    logic [DQ_WIDTH-1:0] slot0;
    logic [DQ_WIDTH-1:0] slot1;
    logic [DQ_WIDTH-1:0] slot2;

    // Slot 3 is never stored: it goes straight into the word together with the held slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0      <= '0;
            slot1      <= '0;
            slot2      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (capture_en) begin
                case (slot)
                    2'd0: slot0 <= dq;
                    2'd1: slot1 <= dq;
                    2'd2: slot2 <= dq;
                    default: begin
                        word       <= {dq, slot2, slot1, slot0};
                        word_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/read_burst_capture.sv
// Read burst capture: opens a DQ capture window a programmable number of cycles
// after each preamble detection and deserialises the burst into 4-beat words.
module read_burst_capture
    import read_burst_capture_pkg::*;
#(
    parameter int DQ_WIDTH       = 8,
    parameter int BEATS_PER_WORD = 4
)
(
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               en_i,
    input  logic                               pattern_detected_i,
    input  logic [DQ_WIDTH-1:0]                dq_i,
    input  logic                               bl_sel_i,
    input  logic [OFFSET_CNT_W-1:0]            rd_offset_i,
    input  logic                               err_clr_i,
    output logic [BEATS_PER_WORD*DQ_WIDTH-1:0] rd_data_o,
    output logic                               rd_valid_o,
    output logic                               burst_done_o,
    output logic                               gate_open_o,
    output logic                               overrun_err_o
);

    state_t                  state;
    state_t                  next_state;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [OFFSET_CNT_W-1:0] offset_cnt;
    logic                    bl_sel_q;
    logic [BEAT_CNT_W-1:0]   last_idx;
    logic                    capture_en;
    logic                    last_beat;
    logic                    overrun_set;
    logic                    gate_next;

    assign last_idx = last_beat_index(bl_sel_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping the enable abandons whatever burst is in flight.
    always_comb begin
        next_state = state;
        if (!en_i) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pattern_detected_i) begin
                        next_state = (rd_offset_i != '0) ? ST_WAIT : ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    if (offset_cnt <= 3'd1) begin
                        next_state = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (beat_cnt == last_idx) begin
                        next_state = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // A detection pulse outside IDLE is only recorded; it never disturbs the running burst.
    always_comb begin
        capture_en  = en_i && (state == ST_CAPTURE);
        last_beat   = capture_en && (beat_cnt == last_idx);
        overrun_set = pattern_detected_i && (state != ST_IDLE);
        gate_next   = (next_state == ST_CAPTURE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            beat_cnt   <= '0;
            offset_cnt <= '0;
            bl_sel_q   <= BL_SEL_BL16;
        end else if (!en_i) begin
            beat_cnt   <= '0;
            offset_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pattern_detected_i) begin
                        bl_sel_q   <= bl_sel_i;
                        offset_cnt <= rd_offset_i;
                        beat_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    offset_cnt <= offset_cnt - 3'd1;
                end
                ST_CAPTURE: begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + 5'd1;
                end
                default: begin
                    beat_cnt   <= '0;
                    offset_cnt <= '0;
                end
            endcase
        end
    end

    // Set has priority over clear so an overrun on the clearing edge is not lost.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            burst_done_o  <= 1'b0;
            gate_open_o   <= 1'b0;
            overrun_err_o <= 1'b0;
        end else begin
            burst_done_o <= last_beat;
            gate_open_o  <= gate_next;
            if (overrun_set) begin
                overrun_err_o <= 1'b1;
            end else if (err_clr_i) begin
                overrun_err_o <= 1'b0;
            end
        end
    end

    rd_deserializer #(
        .DQ_WIDTH (DQ_WIDTH)
    ) u_deser (
        .clk        (clk_i),
        .rst        (reset_i),
        .capture_en (capture_en),
        .slot       (beat_cnt[SLOT_W-1:0]),
        .dq         (dq_i),
        .word       (rd_data_o),
        .word_valid (rd_valid_o)
    );

endmodule

// File: doc/read_burst_capture.md
Name: read_burst_capture

Overview:
- Read-path stage directly downstream of the DQS preamble pattern detector in the Data Manager read module.
- On each single-cycle preamble-detected pulse, opens a capture window after a programmable offset and samples one DQ beat per clock for the burst length.
- Deserialises beats into 4-beat words with a valid strobe toward the read FIFO/controller, and flags preamble pulses that arrive while a burst is active.

Parameters:
- DQ_WIDTH, 8, width of one DQ beat.
- BEATS_PER_WORD, 4, beats packed per output word (fixed at 4; not required to scale).

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- en_i  in  1  block enable; low aborts any burst and holds IDLE.
- pattern_detected_i  in  1  single-cycle preamble-detected pulse from upstream.
- dq_i  in  DQ_WIDTH  DQ beat sampled every clock while capturing.
- bl_sel_i  in  1  0 = BL16 (16 beats), 1 = BC8 (8 beats); latched at burst start.
- rd_offset_i  in  3  cycles (0..7) between detection and first beat; latched at burst start.
- err_clr_i  in  1  clears overrun_err_o.
- rd_data_o  out  4*DQ_WIDTH  packed word; beat 0 in bits [DQ_WIDTH-1:0].
- rd_valid_o  out  1  one-cycle strobe; rd_data_o valid.
- burst_done_o  out  1  one-cycle strobe coincident with the last rd_valid_o of a burst.
- gate_open_o  out  1  high while in CAPTURE.
- overrun_err_o  out  1  sticky: detection pulse seen while not IDLE.

Behaviour:
- Reset (async, reset_i=1): state IDLE, counters 0, rd_data_o=0, rd_valid_o=0, burst_done_o=0, gate_open_o=0, overrun_err_o=0.
- FSM states: IDLE, WAIT, CAPTURE.
- IDLE: if en_i and pattern_detected_i are both high at edge N:
  - latch bl_sel_i and rd_offset_i;
  - go to WAIT if offset>0, else CAPTURE.
- WAIT: offset counter decrements once per edge; enter CAPTURE on the edge where it reaches 0.
- CAPTURE: beat k (0-based) is sampled at edge N+1+offset+k into deserialiser slot k mod 4.
- Word output: rd_valid_o=1 for the cycle following the edge that captures slot 3, with rd_data_o holding the 4 beats.
  - rd_data_o holds its value until the next word; it is not cleared.
- Burst length: BL16 gives 4 words, BC8 gives 2 words. burst_done_o asserts together with the final rd_valid_o.
- Return to IDLE: on the edge capturing the last beat (N+offset+BL), state returns to IDLE.
  - A new pulse at edge N+offset+BL+1 is accepted (back-to-back bursts supported, no gap cycle required).
- gate_open_o: registered; high in cycles where state==CAPTURE.
- Overrun: pattern_detected_i high at any edge while state is WAIT or CAPTURE, including the last-beat edge:
  - sets overrun_err_o at that edge;
  - the current burst continues unaffected and the pulse is otherwise ignored.
- err_clr_i: clears overrun_err_o. If a set and err_clr_i occur on the same edge, set wins.
- en_i low at any edge: return to IDLE, discard partial word and counters, no rd_valid_o/burst_done_o; overrun_err_o retained.
- Reset mid-burst: immediate return to the reset values above; no strobes emitted.
- Counter widths: beat counter 5 bits (0..15), offset counter 3 bits; no wrap beyond BL.

Decomposition:
- Shared read-path package:
  - state encodings IDLE/WAIT/CAPTURE;
  - BL16_BEATS=16, BC8_BEATS=8;
  - bl_sel encoding constants.
- One natural sub-module: rd_deserializer (4-slot beat shifter plus word-valid strobe, driven by a capture-enable and a slot index).

Test Plan:
- BL16, offset 0, dq_i = 0x00..0x0F on consecutive beats, pulse at edge N -> rd_valid_o in cycles after edges N+4/8/12/16; words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; burst_done_o with the 4th word only.
- BC8, offset 5, dq_i = 0xA0..0xA7 -> first beat at edge N+6; words 0xA3A2A1A0, 0xA7A6A5A4; burst_done_o after edge N+13; gate_open_o high for exactly 8 cycles.
- Back-to-back BC8 bursts, offset 0, second pulse at N+9 -> both bursts captured, overrun_err_o=0; second pulse at N+8 -> overrun_err_o=1 and second burst ignored.
- en_i dropped after 6 beats of BL16 -> one rd_valid_o only, no burst_done_o, FSM IDLE; next pulse yields a clean BL16.
- reset_i asserted mid-CAPTURE -> all outputs 0 immediately (asynchronously); err_clr_i on the same edge as an overrun pulse -> overrun_err_o=1.
